pixel_write_buffer: RTL and testbench

- Downstream stage of the MCU message broker. Consumes the 12-bit pixel word and its pixel strobe, which are generated in the MCU bus clock domain.
- Brings each pixel into the system_clock domain, queues it in a small FIFO, and writes it sequentially into frame memory through a request/acknowledge write port.
- Owns the linear frame write address: wrap-around at end of frame, plus an explicit frame restart.

---
 rtl/pixel_write_buffer_if.sv | 24 ++
 rtl/pixel_write_buffer.sv | 143 ++++++++++++++
 tb/tb_pixel_write_buffer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_buffer_if.sv
// Frame memory write port: address/data/request driven by the buffer,
// acknowledge returned by the memory.
interface pixel_write_buffer_if #(
  parameter int ADDR_WIDTH = 17
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [11:0]           mem_data;
  logic                  mem_write_request;
  logic                  mem_write_ack;

  modport master (
    output mem_address,
    output mem_data,
    output mem_write_request,
    input  mem_write_ack
  );

  modport slave (
    input  mem_address,
    input  mem_data,
    input  mem_write_request,
    output mem_write_ack
  );
endinterface

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: synchronises the MCU pixel strobe into system_clock,
// queues pixels in a small FIFO and writes them one at a time into frame
// memory through a request/acknowledge port, owning the linear frame address.
module pixel_write_buffer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_WIDTH   = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                          system_clock,
  input  logic                          reset,
  input  logic                          mcu_pixel_clock,
  input  logic [11:0]                   pixel_data,
  input  logic                          frame_restart,
  pixel_write_buffer_if.master          mem,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]          PTR_ONE   = 1;
  localparam logic [PTR_W:0]          FULL_LVL  = FIFO_DEPTH[PTR_W:0];
  localparam logic [ADDR_WIDTH-1:0]   ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  typedef enum logic {IDLE, REQUEST} state_t;

  // Strobe synchroniser and edge detector
  logic        sync1_q, sync2_q, sync3_q;
  // Pixel word delayed in step with the strobe synchroniser
  logic [11:0] pix1_q, pix2_q;
  logic        strobe_edge;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [11:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level;
  logic             fifo_full, fifo_empty, push, pop;
  logic             overflow_q;

  // Write FSM state and registered outputs
  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [11:0]            data_q;
  logic                   req_q;
  logic                   done_q;
  logic                   restart_pend_q;

  assign strobe_edge = sync2_q & ~sync3_q;
  assign level       = wr_ptr_q - rd_ptr_q;
  assign fifo_full   = (level == FULL_LVL);
  assign fifo_empty  = (level == '0);
  assign push        = strobe_edge & ~fifo_full;
  assign pop         = (state_q == IDLE) & ~fifo_empty;

  assign fifo_level            = level;
  assign overflow              = overflow_q;
  assign frame_done            = done_q;
  assign mem.mem_address       = addr_q;
  assign mem.mem_data          = data_q;
  assign mem.mem_write_request = req_q;

  // Two-flop synchroniser plus one extra flop for rising-edge detection
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= mcu_pixel_clock;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Pixel data pipeline; the word is stable long before the edge is seen
  always_ff @(posedge system_clock) begin
    pix1_q <= pixel_data;
    pix2_q <= pix1_q;
  end

  // FIFO storage write; contents are don't-care until pointed to
  always_ff @(posedge system_clock) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= pix2_q;
  end

  // FIFO pointers and sticky overflow on a push into a full FIFO
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (strobe_edge && fifo_full) overflow_q <= 1'b1;
    end
  end

  // Write FSM: pop into mem_data, hold the request until acked, move address
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      req_q          <= 1'b0;
      done_q         <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_restart) addr_q <= '0;
          if (!fifo_empty) begin
            data_q  <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
            req_q   <= 1'b1;
            state_q <= REQUEST;
          end
        end
        REQUEST: begin
          if (mem.mem_write_ack) begin
            req_q          <= 1'b0;
            state_q        <= IDLE;
            restart_pend_q <= 1'b0;
            // End of frame wins the pulse even when a restart is pending
            if (addr_q == LAST_ADDR) begin
              addr_q <= '0;
              done_q <= 1'b1;
            end else if (restart_pend_q || frame_restart) begin
              addr_q <= '0;
            end else begin
              addr_q <= addr_q + ADDR_ONE;
            end
          end else if (frame_restart) begin
            restart_pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed testbench for pixel_write_buffer: a default-size instance and a
// FRAME_PIXELS=4 instance for the end-of-frame wrap.
module tb_pixel_write_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        strobe, restart;
  logic [11:0] pix;
  logic        strobe4, restart4;
  logic [11:0] pix4;
  logic [3:0]  lvl, lvl4;
  logic        ovf, ovf4, fd, fd4;

  pixel_write_buffer_if #(.ADDR_WIDTH(17)) m  ();
  pixel_write_buffer_if #(.ADDR_WIDTH(17)) m4 ();

  pixel_write_buffer #(.FIFO_DEPTH(8), .ADDR_WIDTH(17), .FRAME_PIXELS(76800)) dut (
    .system_clock(clk), .reset(rst), .mcu_pixel_clock(strobe), .pixel_data(pix),
    .frame_restart(restart), .mem(m), .fifo_level(lvl), .overflow(ovf), .frame_done(fd)
  );

  pixel_write_buffer #(.FIFO_DEPTH(8), .ADDR_WIDTH(17), .FRAME_PIXELS(4)) dut4 (
    .system_clock(clk), .reset(rst), .mcu_pixel_clock(strobe4), .pixel_data(pix4),
    .frame_restart(restart4), .mem(m4), .fifo_level(lvl4), .overflow(ovf4), .frame_done(fd4)
  );

  int total  = 0;
  int passed = 0;
  int fd_cnt  = 0;
  int fd4_cnt = 0;

  always @(negedge clk) begin
    if (fd)  fd_cnt  <= fd_cnt + 1;
    if (fd4) fd4_cnt <= fd4_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000ns");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    strobe = 1'b0; strobe4 = 1'b0; restart = 1'b0; restart4 = 1'b0;
    pix = '0; pix4 = '0;
    m.mem_write_ack = 1'b0; m4.mem_write_ack = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic send_pixel(input logic [11:0] d);
    pix = d; strobe = 1'b1;
    repeat (4) tick;
    strobe = 1'b0;
    repeat (4) tick;
  endtask

  task automatic send_pixel4(input logic [11:0] d);
    pix4 = d; strobe4 = 1'b1;
    repeat (4) tick;
    strobe4 = 1'b0;
    repeat (4) tick;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m.mem_write_request) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic wait_req4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m4.mem_write_request) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic ack_once;
    m.mem_write_ack = 1'b1;
    tick;
    m.mem_write_ack = 1'b0;
  endtask

  task automatic ack_once4;
    m4.mem_write_ack = 1'b1;
    tick;
    m4.mem_write_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++; if (m.mem_address !== 17'd0) $display("FAIL rst_addr: got %0d required 0", m.mem_address); else passed++;
    total++; if (m.mem_data !== 12'h000) $display("FAIL rst_data: got %h required 000", m.mem_data); else passed++;
    total++; if (m.mem_write_request !== 1'b0) $display("FAIL rst_req: got %b required 0", m.mem_write_request); else passed++;
    total++; if (lvl !== 4'd0) $display("FAIL rst_level: got %0d required 0", lvl); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL rst_overflow: got %b required 0", ovf); else passed++;
    total++; if (fd !== 1'b0) $display("FAIL rst_frame_done: got %b required 0", fd); else passed++;
    do_reset;
  endtask

  task automatic test_single;
    bit ok;
    do_reset;
    pix = 12'hABC; strobe = 1'b1;
    wait_req(ok);
    total++; if (!ok) $display("FAIL single_req_timeout: got no request, required request"); else passed++;
    total++; if (m.mem_address !== 17'd0) $display("FAIL single_addr: got %0d required 0", m.mem_address); else passed++;
    total++; if (m.mem_data !== 12'hABC) $display("FAIL single_data: got %h required abc", m.mem_data); else passed++;
    ack_once;
    strobe = 1'b0;
    total++; if (m.mem_write_request !== 1'b0) $display("FAIL single_req_drop: got %b required 0", m.mem_write_request); else passed++;
    total++; if (m.mem_address !== 17'd1) $display("FAIL single_addr_next: got %0d required 1", m.mem_address); else passed++;
    total++; if (lvl !== 4'd0) $display("FAIL single_level: got %0d required 0", lvl); else passed++;
  endtask

  // The first word is popped into mem_data immediately, so the FIFO then
  // holds 0x002..0x009 and only 0x00A is dropped.
  task automatic test_burst_overflow;
    bit ok;
    do_reset;
    for (int i = 1; i <= 10; i++) send_pixel(12'(i));
    total++; if (lvl !== 4'd8) $display("FAIL burst_level: got %0d required 8", lvl); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL burst_overflow: got %b required 1", ovf); else passed++;
    for (int i = 0; i < 9; i++) begin
      wait_req(ok);
      total++; if (!ok) $display("FAIL burst_req_timeout: write %0d got no request", i); else passed++;
      total++; if (m.mem_address !== 17'(i)) $display("FAIL burst_addr: write %0d got %0d required %0d", i, m.mem_address, i); else passed++;
      total++; if (m.mem_data !== 12'(i + 1)) $display("FAIL burst_data: write %0d got %h required %h", i, m.mem_data, 12'(i + 1)); else passed++;
      ack_once;
    end
    repeat (10) tick;
    total++; if (m.mem_write_request !== 1'b0) $display("FAIL burst_no_extra_write: got req %b data %h required no request", m.mem_write_request, m.mem_data); else passed++;
    total++; if (lvl !== 4'd0) $display("FAIL burst_drained: got %0d required 0", lvl); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL burst_overflow_sticky: got %b required 1", ovf); else passed++;
  endtask

  task automatic test_frame_wrap;
    bit ok;
    int base;
    do_reset;
    base = fd4_cnt;
    for (int i = 0; i < 5; i++) begin
      send_pixel4(12'(12'h100 + i));
      wait_req4(ok);
      total++; if (!ok) $display("FAIL wrap_req_timeout: write %0d got no request", i); else passed++;
      total++; if (m4.mem_address !== 17'(i % 4)) $display("FAIL wrap_addr: write %0d got %0d required %0d", i, m4.mem_address, i % 4); else passed++;
      ack_once4;
      total++; if (fd4 !== (i == 3)) $display("FAIL wrap_frame_done: after write %0d got %b required %b", i, fd4, (i == 3)); else passed++;
    end
    tick;
    total++; if (m4.mem_address !== 17'd1) $display("FAIL wrap_addr_final: got %0d required 1", m4.mem_address); else passed++;
    total++; if (fd4_cnt - base !== 1) $display("FAIL wrap_done_count: got %0d required 1", fd4_cnt - base); else passed++;
  endtask

  task automatic test_restart;
    bit ok;
    int base;
    do_reset;
    base = fd_cnt;
    for (int i = 0; i < 5; i++) begin
      send_pixel(12'(12'h200 + i));
      wait_req(ok);
      ack_once;
    end
    send_pixel(12'h205);
    wait_req(ok);
    total++; if (m.mem_address !== 17'd5) $display("FAIL restart_pre_addr: got %0d required 5", m.mem_address); else passed++;
    restart = 1'b1; tick; restart = 1'b0; tick;
    total++; if (m.mem_address !== 17'd5) $display("FAIL restart_hold_addr: got %0d required 5", m.mem_address); else passed++;
    total++; if (m.mem_write_request !== 1'b1) $display("FAIL restart_hold_req: got %b required 1", m.mem_write_request); else passed++;
    total++; if (m.mem_data !== 12'h205) $display("FAIL restart_hold_data: got %h required 205", m.mem_data); else passed++;
    ack_once;
    total++; if (m.mem_address !== 17'd0) $display("FAIL restart_addr_zero: got %0d required 0", m.mem_address); else passed++;
    send_pixel(12'h206);
    wait_req(ok);
    total++; if (m.mem_address !== 17'd0 || m.mem_data !== 12'h206) $display("FAIL restart_next_write: got addr %0d data %h required addr 0 data 206", m.mem_address, m.mem_data); else passed++;
    ack_once;
    restart = 1'b1; tick; restart = 1'b0;
    total++; if (m.mem_address !== 17'd0) $display("FAIL restart_idle: got %0d required 0", m.mem_address); else passed++;
    total++; if (fd_cnt - base !== 0) $display("FAIL restart_no_done: got %0d pulses required 0", fd_cnt - base); else passed++;
  endtask

  task automatic test_held_strobe;
    do_reset;
    pix = 12'h3C3; strobe = 1'b1;
    repeat (20) tick;
    strobe = 1'b0;
    total++; if (m.mem_write_request !== 1'b1 || m.mem_data !== 12'h3C3) $display("FAIL held_first_write: got req %b data %h required req 1 data 3c3", m.mem_write_request, m.mem_data); else passed++;
    total++; if (lvl !== 4'd0) $display("FAIL held_level: got %0d required 0", lvl); else passed++;
    ack_once;
    repeat (10) tick;
    total++; if (m.mem_write_request !== 1'b0) $display("FAIL held_single_push: got req %b required 0", m.mem_write_request); else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    do_reset;
    for (int i = 1; i <= 4; i++) send_pixel(12'(12'h300 + i));
    total++; if (lvl !== 4'd3) $display("FAIL mid_level_before: got %0d required 3", lvl); else passed++;
    total++; if (m.mem_write_request !== 1'b1) $display("FAIL mid_req_before: got %b required 1", m.mem_write_request); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (m.mem_write_request !== 1'b0) $display("FAIL mid_req_async: got %b required 0", m.mem_write_request); else passed++;
    total++; if (lvl !== 4'd0) $display("FAIL mid_level_async: got %0d required 0", lvl); else passed++;
    total++; if (m.mem_address !== 17'd0 || m.mem_data !== 12'h000) $display("FAIL mid_addr_data_async: got addr %0d data %h required 0/000", m.mem_address, m.mem_data); else passed++;
    tick;
    rst = 1'b0;
    seen = 1'b0;
    m.mem_write_ack = 1'b1;
    repeat (20) begin
      tick;
      if (m.mem_write_request) seen = 1'b1;
    end
    m.mem_write_ack = 1'b0;
    total++; if (seen !== 1'b0) $display("FAIL mid_no_write_after: got request required none"); else passed++;
    send_pixel(12'h155);
    wait_req(ok);
    total++; if (!ok || m.mem_data !== 12'h155 || m.mem_address !== 17'd0) $display("FAIL mid_new_write: got req %b addr %0d data %h required 1/0/155", ok, m.mem_address, m.mem_data); else passed++;
    ack_once;
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst_overflow;
    test_frame_wrap;
    test_restart;
    test_held_strobe;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
